// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU adder arbiter
package alu_arb_pkg;

    typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_EXEC} grant_e;

    localparam logic ALU_FUNC_INC4 = 1'b0;
    localparam logic ALU_FUNC_ADD  = 1'b1;
    localparam int   CNT_W         = 4;

endpackage

// File: rtl/alu_rsp_slot.sv
// rtl/alu_rsp_slot.sv - one-entry valid/ready response buffer
module alu_rsp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              free
);

    // A full slot that drains this cycle can accept a new result on the same edge.
    assign free = !rsp_valid || rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - fetch/execute arbiter for the shared ALU adder; ALU_ARB_STATS_EN adds conflict/force counters
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req_valid,
    output logic        f_req_ready,
    input  logic [31:0] f_pc,
    output logic        f_rsp_valid,
    input  logic        f_rsp_ready,
    output logic [31:0] f_rsp_data,
    input  logic        x_req_valid,
    output logic        x_req_ready,
    input  logic [31:0] x_opa,
    input  logic [31:0] x_opb,
    output logic        x_rsp_valid,
    input  logic        x_rsp_ready,
    output logic [31:0] x_rsp_data,
    output logic        x_rsp_carry,
    output logic [31:0] alu_opa,
    output logic [31:0] alu_opb,
    output logic        alu_func,
    input  logic [31:0] alu_res,
    input  logic        alu_carry
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] conflict_cnt,
    output logic [15:0] force_cnt
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             f_free;
    logic             x_free;
    logic             force_x;
    logic             f_gnt;
    logic             x_gnt;
    logic [CNT_W-1:0] cnt;
    logic [32:0]      x_slot_data;
    grant_e           grant;

    assign force_x = (cnt == LIMIT);

    assign f_req_ready = f_free && !(x_req_valid && x_free && force_x);
    assign x_req_ready = x_free && !(f_req_valid && f_free && !force_x);

    // The ready equations make the two handshakes mutually exclusive.
    assign f_gnt = f_req_valid && f_req_ready;
    assign x_gnt = x_req_valid && x_req_ready;

    always_comb begin
        grant = GNT_NONE;
        if (f_gnt) begin
            grant = GNT_FETCH;
        end else if (x_gnt) begin
            grant = GNT_EXEC;
        end
    end

    always_comb begin
        alu_opa  = '0;
        alu_opb  = '0;
        alu_func = ALU_FUNC_INC4;
        case (grant)
            GNT_FETCH: begin
                alu_opa  = f_pc;
                alu_opb  = '0;
                alu_func = ALU_FUNC_INC4;
            end
            GNT_EXEC: begin
                alu_opa  = x_opa;
                alu_opb  = x_opb;
                alu_func = ALU_FUNC_ADD;
            end
            default: begin
                alu_opa  = '0;
                alu_opb  = '0;
                alu_func = ALU_FUNC_INC4;
            end
        endcase
    end

    // Counts fetch wins that actually kept a ready execute waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (f_gnt && x_req_valid && x_free) begin
            cnt <= force_x ? cnt : cnt + 1'b1;
        end else if (x_gnt || !x_req_valid) begin
            cnt <= '0;
        end
    end

    alu_rsp_slot #(.DATA_W(32)) u_f_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (f_gnt),
        .load_data (alu_res),
        .rsp_ready (f_rsp_ready),
        .rsp_valid (f_rsp_valid),
        .rsp_data  (f_rsp_data),
        .free      (f_free)
    );

    alu_rsp_slot #(.DATA_W(33)) u_x_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (x_gnt),
        .load_data ({alu_carry, alu_res}),
        .rsp_ready (x_rsp_ready),
        .rsp_valid (x_rsp_valid),
        .rsp_data  (x_slot_data),
        .free      (x_free)
    );

    assign x_rsp_data  = x_slot_data[31:0];
    assign x_rsp_carry = x_slot_data[32];

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            force_cnt    <= '0;
        end else begin
            if (f_req_valid && x_req_valid && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            // Forced means execute took the slot that fetch would otherwise have won.
            if (x_gnt && force_x && f_req_valid && f_free && force_cnt != 16'hFFFF) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
    logic [31:0] f_pc, f_rsp_data;
    logic        x_req_valid, x_req_ready, x_rsp_valid, x_rsp_ready, x_rsp_carry;
    logic [31:0] x_opa, x_opb, x_rsp_data;
    logic [31:0] alu_opa, alu_opb, alu_res;
    logic        alu_func, alu_carry;
    logic [32:0] alu_sum;

    typedef struct {
        logic [32:0] d;
        int          cyc;
        bit          seen;
    } exp_t;

    exp_t  fq[$];
    exp_t  xq[$];
    string glog;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign alu_sum   = alu_func ? ({1'b0, alu_opa} + {1'b0, alu_opb}) : ({1'b0, alu_opa} + 33'd4);
    assign alu_res   = alu_sum[31:0];
    assign alu_carry = alu_sum[32];

    alu_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_pc        (f_pc),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_ready (f_rsp_ready),
        .f_rsp_data  (f_rsp_data),
        .x_req_valid (x_req_valid),
        .x_req_ready (x_req_ready),
        .x_opa       (x_opa),
        .x_opb       (x_opb),
        .x_rsp_valid (x_rsp_valid),
        .x_rsp_ready (x_rsp_ready),
        .x_rsp_data  (x_rsp_data),
        .x_rsp_carry (x_rsp_carry),
        .alu_opa     (alu_opa),
        .alu_opb     (alu_opb),
        .alu_func    (alu_func),
        .alu_res     (alu_res),
        .alu_carry   (alu_carry)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: responses are checked first, then this cycle's grant is scored.
    always @(negedge clk) begin
        if (rst_n) begin
            if (f_rsp_valid) begin
                if (fq.size() == 0) begin
                    chk("f_rsp_spurious", 64'(f_rsp_valid), 64'd0);
                end else begin
                    if (!fq[0].seen) begin
                        chk("f_rsp_latency", 64'(cyc), 64'(fq[0].cyc + 1));
                        fq[0].seen = 1'b1;
                    end
                    chk("f_rsp_data", 64'(f_rsp_data), 64'(fq[0].d[31:0]));
                    if (f_rsp_ready) void'(fq.pop_front());
                end
            end
            if (x_rsp_valid) begin
                if (xq.size() == 0) begin
                    chk("x_rsp_spurious", 64'(x_rsp_valid), 64'd0);
                end else begin
                    if (!xq[0].seen) begin
                        chk("x_rsp_latency", 64'(cyc), 64'(xq[0].cyc + 1));
                        xq[0].seen = 1'b1;
                    end
                    chk("x_rsp_data", 64'({x_rsp_carry, x_rsp_data}), 64'(xq[0].d));
                    if (x_rsp_ready) void'(xq.pop_front());
                end
            end
            if (f_req_valid && f_req_ready && x_req_valid && x_req_ready)
                chk("double_grant", 64'd1, 64'd0);
            if (f_req_valid && f_req_ready) begin
                chk("f_alu_drive", {alu_opa, alu_opb[30:0], alu_func}, {f_pc, 31'd0, 1'b0});
                fq.push_back('{d: {1'b0, f_pc + 32'd4}, cyc: cyc, seen: 1'b0});
                glog = {glog, "F"};
            end else if (x_req_valid && x_req_ready) begin
                chk("x_alu_drive", {alu_opa, alu_opb[30:0], alu_func}, {x_opa, x_opb[30:0], 1'b1});
                xq.push_back('{d: {1'b0, x_opa} + {1'b0, x_opb}, cyc: cyc, seen: 1'b0});
                glog = {glog, "X"};
            end else begin
                chk("idle_alu", {alu_opa, alu_opb[30:0], alu_func}, 64'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        f_req_valid = 0; f_pc = 0; f_rsp_ready = 1;
        x_req_valid = 0; x_opa = 0; x_opb = 0; x_rsp_ready = 1;
        glog = "";
        step(); step();
        chk("rst_rsp_valid", {62'd0, f_rsp_valid, x_rsp_valid}, 64'd0);
        chk("rst_rsp_data", {f_rsp_data, x_rsp_data}, 64'd0);
        chk("rst_carry", 64'(x_rsp_carry), 64'd0);
        chk("rst_readys", {62'd0, f_req_ready, x_req_ready}, 64'd3);
        rst_n = 1'b1;
        step();

        // Fetch only
        f_req_valid = 1; f_pc = 32'h0000_0100;
        step();
        f_req_valid = 0;
        chk("t1_f_valid", 64'(f_rsp_valid), 64'd1);
        chk("t1_f_data", 64'(f_rsp_data), 64'h0000_0104);
        step();

        // Execute only, carry out of the top bit
        x_req_valid = 1; x_opa = 32'hFFFF_FFFF; x_opb = 32'h0000_0001;
        step();
        x_req_valid = 0;
        chk("t2_x_valid", 64'(x_rsp_valid), 64'd1);
        chk("t2_x_data", {31'd0, x_rsp_carry, x_rsp_data}, {31'd0, 1'b1, 32'h0});
        step();

        // Contention: starvation limit forces every fifth grant to execute
        glog = "";
        for (int i = 0; i < 10; i++) begin
            f_req_valid = 1; f_pc = 32'h1000 + 32'(i * 4);
            x_req_valid = 1; x_opa = 32'h0100_0000 * 32'(i); x_opb = 32'h8000_0000 + 32'(i);
            step();
        end
        f_req_valid = 0; x_req_valid = 0;
        step();
        chk_str("t3_grant_seq", glog, "FFFFXFFFFX");

        // Fetch slot blocked: execute granted every cycle
        glog = "";
        f_rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            f_req_valid = 1; f_pc = 32'h2000 + 32'(i * 4);
            x_req_valid = 1; x_opa = 32'h1111_0000 + 32'(i); x_opb = 32'hF000_0000;
            #1;
            if (i > 0) chk("t4_f_req_ready", 64'(f_req_ready), 64'd0);
            step();
        end
        f_req_valid = 0; x_req_valid = 0; f_rsp_ready = 1;
        step(); step();
        chk_str("t4_grant_seq", glog, "FXXXX");

        // Alternating streams: one grant every cycle
        glog = "";
        for (int i = 0; i < 8; i++) begin
            f_req_valid = (i % 2 == 0); f_pc = 32'hFFFF_FFF0 + 32'(i);
            x_req_valid = (i % 2 == 1); x_opa = 32'(i * 7); x_opb = 32'hFFFF_FFF8;
            step();
        end
        f_req_valid = 0; x_req_valid = 0;
        step();
        chk_str("t5_grant_seq", glog, "FXFXFXFX");

        // Reset with both slots full
        f_rsp_ready = 0; x_rsp_ready = 0;
        f_req_valid = 1; f_pc = 32'h3000; x_req_valid = 1; x_opa = 32'h5; x_opb = 32'h6;
        step(); step();
        f_req_valid = 0; x_req_valid = 0;
        step();
        chk("t6_full", {62'd0, f_rsp_valid, x_rsp_valid}, 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {62'd0, f_rsp_valid, x_rsp_valid}, 64'd0);
        chk("t6_rst_data", {f_rsp_data, x_rsp_data}, 64'd0);
        chk("t6_rst_carry", 64'(x_rsp_carry), 64'd0);
        fq.delete(); xq.delete();
        step();
        rst_n = 1'b1;
        f_rsp_ready = 1; x_rsp_ready = 1;
        glog = "";
        for (int i = 0; i < 5; i++) begin
            f_req_valid = 1; f_pc = 32'h4000 + 32'(i * 4);
            x_req_valid = 1; x_opa = 32'h7FFF_FFFF; x_opb = 32'(i + 1);
            step();
        end
        f_req_valid = 0; x_req_valid = 0;
        step(); step();
        chk_str("t6_grant_seq", glog, "FFFFX");

        chk("drain_fq", 64'(fq.size()), 64'd0);
        chk("drain_xq", 64'(xq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
